uart_receiver: RTL

Receive side of the UART: the stage directly downstream of uart_transmitter's TxD line. It deserialises 11-bit frames (start, 8 data LSB-first, even parity, stop) from RxD using 16x oversampling. It presents each byte on Rx_DATA with a one-cycle Rx_VALID strobe, plus framing and parity error flags.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rx_baud_tick.sv | 34 +++
 rtl/uart_receiver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states, baud table,
// frame geometry, oversample sample points and the per-baud divisor function.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;

   localparam int BAUD_RATE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

   localparam int FRAME_DATA_BITS = 8;

   // Sample points within a 16-tick bit; the majority vote is ready at TICK_S2.
   localparam int TICK_S0  = 7;
   localparam int TICK_MID = 8;
   localparam int TICK_S2  = 9;
   localparam int TICK_END = 15;

   // Rounded clock cycles per oversample tick.
   function automatic int baud_div(input int clk_hz, input logic [2:0] sel);
      return (clk_hz + 8 * BAUD_RATE[sel]) / (16 * BAUD_RATE[sel]);
   endfunction

endpackage

// File: rtl/rx_baud_tick.sv
// Oversample tick generator: one-cycle tick every divisor cycles, held cleared
// while i_restart is high so ticks line up with the detected start edge.
module rx_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_restart,
   input  logic [2:0] i_baud_sel,
   output logic       o_tick
);
   localparam int CW = $clog2(baud_div(CLK_FREQ_HZ, 3'd0) + 1);

   logic [7:0][CW-1:0] w_div_m1;
   logic [CW-1:0]      r_cnt;

   for (genvar g = 0; g < 8; g++) begin : g_div
      assign w_div_m1[g] = CW'(baud_div(CLK_FREQ_HZ, 3'(g)) - 1);
   end

   assign o_tick = !i_restart && (r_cnt == w_div_m1[i_baud_sel]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (i_restart || o_tick)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver for 8E1 frames: 2-flop RxD synchroniser, 16x oversampled frame
// FSM with 3-sample majority vote, and registered byte/strobe/error outputs.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int OVERSAMPLE  = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR
);
   localparam int TW = $clog2(OVERSAMPLE);

   rx_state_e                  r_state, w_next;
   logic                       r_sync1, r_sync2, r_rx_prev;
   logic [2:0]                 r_baud;
   logic [TW-1:0]              r_tcnt;
   logic [3:0]                 r_bit;
   logic [FRAME_DATA_BITS-1:0] r_shift, r_data;
   logic                       r_s7, r_s8, r_bitval;
   logic                       r_valid, r_perr, r_ferr;
   logic                       w_rx, w_tick, w_restart, w_start;
   logic                       w_mid, w_end, w_maj, w_deliver;

   assign w_rx      = r_sync2;
   assign w_restart = (r_state == IDLE);
   assign w_start   = (r_state == IDLE) && Rx_EN && r_rx_prev && !w_rx;
   assign w_maj     = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);
   assign w_mid     = w_tick && (r_tcnt == TW'(TICK_S2));
   assign w_end     = w_tick && (r_tcnt == TW'(TICK_END));

   rx_baud_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
      .clock      (clock),
      .reset      (reset),
      .i_restart  (w_restart),
      .i_baud_sel (r_baud),
      .o_tick     (w_tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // START hands over to DATA at mid-bit; the first end-of-bit seen in DATA is
   // still the start bit's tail, hence r_bit begins at all-ones.
   always_comb begin
      w_next    = r_state;
      w_deliver = 1'b0;
      case (r_state)
         IDLE:   if (w_start) w_next = START;
         START:  if (w_tick && r_tcnt == TW'(TICK_MID)) w_next = w_rx ? IDLE : DATA;
         DATA:   if (w_end && r_bit == 4'(FRAME_DATA_BITS - 1)) w_next = PARITY;
         PARITY: if (w_end) w_next = STOP;
         STOP: begin
            if (w_mid) begin
               w_deliver = 1'b1;
               w_next    = w_maj ? IDLE : BREAK;
            end
         end
         BREAK:  if (w_rx) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (!Rx_EN) begin
         w_next    = IDLE;
         w_deliver = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
         r_baud    <= '0;
         r_tcnt    <= '0;
         r_bit     <= '1;
         r_shift   <= '0;
         r_s7      <= 1'b0;
         r_s8      <= 1'b0;
         r_bitval  <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_sync1   <= RxD;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
         r_valid   <= w_deliver;

         if (r_state == IDLE) begin
            r_tcnt <= '0;
            r_bit  <= '1;
         end else if (w_tick) begin
            r_tcnt <= r_tcnt + TW'(1);
         end

         if (w_start) begin
            r_baud <= baud_select;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
         end

         if (w_tick && r_tcnt == TW'(TICK_S0))  r_s7 <= w_rx;
         if (w_tick && r_tcnt == TW'(TICK_MID)) r_s8 <= w_rx;
         if (w_mid)                             r_bitval <= w_maj;

         if (r_state == DATA && w_end) begin
            if (r_bit != '1) r_shift <= {r_bitval, r_shift[FRAME_DATA_BITS-1:1]};
            r_bit <= r_bit + 4'd1;
         end

         // r_bitval still holds the parity vote when the stop decision is made.
         if (w_deliver) begin
            r_data <= r_shift;
            r_perr <= (^r_shift) ^ r_bitval;
            r_ferr <= ~w_maj;
         end
      end
   end

   assign Rx_DATA   = r_data;
   assign Rx_VALID  = r_valid;
   assign Rx_PERROR = r_perr;
   assign Rx_FERROR = r_ferr;

endmodule
